ysyx_25030093_lsu: RTL and testbench

Multi-cycle load/store unit sitting directly downstream of the ALU: it takes the effective address, store data and access type computed in execute and performs the memory access over a valid/ready request/response bus, replacing direct combinational memory calls. It performs byte-lane steering and write-mask generation for stores, and lane extraction with sign/zero extension for loads. It hands the load result to write-back through a valid/ready handshake.

---
 rtl/ysyx_25030093_lsu.sv | 172 +++++++++++++++++
 tb/tb_ysyx_25030093_lsu.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25030093_lsu.sv
// ysyx_25030093_lsu: multi-cycle load/store unit between execute and write-back.
// Accepts one access at a time, issues it on a valid/ready memory bus, steers
// store bytes into lanes, and extracts/extends load data for write-back.
// Optional feature macro: LSU_MISALIGN_CHECK_EN (flags misaligned h/w accesses
// with out_err and completes them without touching memory).
//
// Handshake rule for every valid/ready pair (in_*, mem_req_*, mem_resp_*, out_*):
// a transfer happens on a rising edge where valid and ready are both high; a
// producer keeps valid and its payload stable until that edge.
module ysyx_25030093_lsu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_wen,
  input  logic [2:0]  in_funct3,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_resp_valid,
  output logic        mem_resp_ready,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_rdata,
  output logic        out_err,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2, DONE = 2'd3} state_t;

  state_t      state_q, state_d;
  logic        wen_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        accept;
  logic        misalign;
  logic [31:0] st_wdata;
  logic [3:0]  st_mask;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] ld_data;

  assign accept    = in_valid && in_ready;
  assign dbg_state = state_q;

`ifdef LSU_MISALIGN_CHECK_EN
  logic err_q;
  // Halfword needs addr[0]=0; any word-class code (funct3[1]=1) needs addr[1:0]=0.
  assign misalign = ((in_funct3[1:0] == 2'b01) && in_addr[0]) ||
                    (in_funct3[1] && (in_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  // Store lane replication and byte strobes from the latched access.
  always_comb begin
    st_wdata = wdata_q;
    st_mask  = 4'b1111;
    case (f3_q[1:0])
      2'b00: begin
        st_wdata = {4{wdata_q[7:0]}};
        st_mask  = 4'b0001 << addr_q[1:0];
      end
      2'b01: begin
        st_wdata = {2{wdata_q[15:0]}};
        st_mask  = 4'b0011 << {addr_q[1], 1'b0};
      end
      default: begin
        st_wdata = wdata_q;
        st_mask  = 4'b1111;
      end
    endcase
  end

  // Load lane extraction with sign (b/h) or zero (bu/hu) extension.
  always_comb begin
    lane_b  = 8'h00;
    lane_h  = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    ld_data = mem_rdata;
    case (addr_q[1:0])
      2'b00:   lane_b = mem_rdata[7:0];
      2'b01:   lane_b = mem_rdata[15:8];
      2'b10:   lane_b = mem_rdata[23:16];
      default: lane_b = mem_rdata[31:24];
    endcase
    case (f3_q[1:0])
      2'b00:   ld_data = f3_q[2] ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
      2'b01:   ld_data = f3_q[2] ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
      default: ld_data = mem_rdata;
    endcase
  end

  // Next-state and bus outputs; memory fields are driven only while requesting.
  always_comb begin
    state_d        = state_q;
    in_ready       = 1'b0;
    mem_req_valid  = 1'b0;
    mem_wen        = 1'b0;
    mem_addr       = 32'h0;
    mem_wdata      = 32'h0;
    mem_wmask      = 4'h0;
    mem_resp_ready = 1'b0;
    out_valid      = 1'b0;
    out_rdata      = 32'h0;
    case (state_q)
      IDLE: begin
        in_ready = rst_n;
        if (in_valid && rst_n) state_d = misalign ? DONE : REQ;
      end
      REQ: begin
        mem_req_valid = 1'b1;
        mem_wen       = wen_q;
        mem_addr      = {addr_q[31:2], 2'b00};
        mem_wdata     = wen_q ? st_wdata : 32'h0;
        mem_wmask     = wen_q ? st_mask : 4'h0;
        if (mem_req_ready) state_d = RESP;
      end
      RESP: begin
        mem_resp_ready = 1'b1;
        if (mem_resp_valid) state_d = DONE;
      end
      default: begin
        out_valid = 1'b1;
        out_rdata = rdata_q;
        if (out_ready) state_d = IDLE;
      end
    endcase
  end

`ifdef LSU_MISALIGN_CHECK_EN
  assign out_err = (state_q == DONE) && err_q;
`else
  assign out_err = 1'b0;
`endif

  // State register and latched access/result; reset abandons any outstanding access.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wen_q   <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
`ifdef LSU_MISALIGN_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (accept) begin
        wen_q   <= in_wen;
        f3_q    <= in_funct3;
        addr_q  <= in_addr;
        wdata_q <= in_wdata;
        rdata_q <= 32'h0;
`ifdef LSU_MISALIGN_CHECK_EN
        err_q   <= misalign;
`endif
      end
      if ((state_q == RESP) && mem_resp_valid) rdata_q <= wen_q ? 32'h0 : ld_data;
    end
  end

endmodule

// File: tb/tb_ysyx_25030093_lsu.sv
// Directed testbench for ysyx_25030093_lsu: hand-computed vectors, cycle-exact
// handshake timing, stalls, reset during an access, and misaligned handling.
module tb_ysyx_25030093_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_wen = 1'b0;
  logic [2:0]  in_funct3 = 3'b000;
  logic [31:0] in_addr = 32'h0;
  logic [31:0] in_wdata = 32'h0;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_resp_valid = 1'b0;
  logic        mem_resp_ready;
  logic [31:0] mem_rdata = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_rdata;
  logic        out_err;
  logic [1:0]  dbg_state;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;

  ysyx_25030093_lsu dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_wen(in_wen),
    .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_resp_valid(mem_resp_valid),
    .mem_resp_ready(mem_resp_ready), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata),
    .out_err(out_err), .dbg_state(dbg_state)
  );

  // clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // One access with rw/sw/ow stall cycles on req_ready/resp_valid/out_ready.
  // Cycle N is the cycle whose closing edge accepts; cycle N+k has cyc == base+k.
  task automatic access(input string tag, input logic wen, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input int rw, input int sw, input int ow,
                        input logic [31:0] e_addr, input logic [31:0] e_wdata,
                        input logic [3:0] e_mask, input logic [31:0] e_rdata);
    int base;
    @(negedge clk);
    check({tag, ".idle_ready"}, in_ready, 1);
    base = cyc;
    in_valid = 1'b1; in_wen = wen; in_funct3 = f3; in_addr = addr; in_wdata = wdata;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; out_ready = 1'b0;
    for (int k = 0; k <= rw; k++) begin
      @(negedge clk);
      if (k == 0) check({tag, ".req_cycle"}, cyc, base + 1);
      check({tag, ".req_valid"}, mem_req_valid, 1);
      check({tag, ".in_ready_busy"}, in_ready, 0);
      check({tag, ".mem_wen"}, mem_wen, wen);
      check({tag, ".mem_addr"}, mem_addr, e_addr);
      check({tag, ".mem_wdata"}, mem_wdata, e_wdata);
      check({tag, ".mem_wmask"}, mem_wmask, e_mask);
      // a second offer with different fields must be ignored
      in_valid = (k < rw);
      in_wen = ~wen; in_funct3 = 3'b010; in_addr = addr ^ 32'h0000_00F0; in_wdata = ~wdata;
      mem_req_ready = (k == rw);
    end
    for (int k = 0; k <= sw; k++) begin
      @(negedge clk);
      check({tag, ".resp_ready"}, mem_resp_ready, 1);
      check({tag, ".req_dropped"}, mem_req_valid, 0);
      in_valid = 1'b0;
      mem_req_ready = 1'b0;
      mem_resp_valid = (k == sw);
      mem_rdata = (k == sw) ? rdata : ~rdata;
    end
    for (int k = 0; k <= ow; k++) begin
      @(negedge clk);
      if (k == 0) check({tag, ".done_cycle"}, cyc, base + 3 + rw + sw);
      check({tag, ".out_valid"}, out_valid, 1);
      check({tag, ".out_rdata"}, out_rdata, e_rdata);
      check({tag, ".out_err"}, out_err, 0);
      check({tag, ".resp_ready_done"}, mem_resp_ready, 0);
      mem_resp_valid = 1'b0;
      mem_rdata = 32'h0BAD_0BAD;
      out_ready = (k == ow);
    end
    @(negedge clk);
    check({tag, ".back_idle"}, in_ready, 1);
    check({tag, ".out_cleared"}, out_valid, 0);
    out_ready = 1'b0;
  endtask

`ifdef LSU_MISALIGN_CHECK_EN
  // Misaligned access: completes at N+1 with out_err and never touches memory.
  task automatic misaligned(input string tag, input logic wen, input logic [2:0] f3,
                            input logic [31:0] addr);
    int base;
    @(negedge clk);
    base = cyc;
    in_valid = 1'b1; in_wen = wen; in_funct3 = f3; in_addr = addr; in_wdata = 32'hFFFF_FFFF;
    mem_req_ready = 1'b1; mem_resp_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, ".done_cycle"}, cyc, base + 1);
    check({tag, ".out_valid"}, out_valid, 1);
    check({tag, ".out_err"}, out_err, 1);
    check({tag, ".out_rdata"}, out_rdata, 0);
    check({tag, ".no_req"}, mem_req_valid, 0);
    check({tag, ".no_wmask"}, mem_wmask, 0);
    out_ready = 1'b1;
    @(negedge clk);
    check({tag, ".idle"}, in_ready, 1);
    check({tag, ".no_req_after"}, mem_req_valid, 0);
    check({tag, ".out_cleared"}, out_valid, 0);
    out_ready = 1'b0; mem_req_ready = 1'b0;
  endtask
`endif

  initial begin
    // reset
    repeat (2) @(negedge clk);
    check("rst.in_ready", in_ready, 0);
    check("rst.req_valid", mem_req_valid, 0);
    check("rst.out_valid", out_valid, 0);
    check("rst.out_rdata", out_rdata, 0);
    check("rst.mem_addr", mem_addr, 0);
    check("rst.state", dbg_state, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst.in_ready_after", in_ready, 1);
    check("rst.out_err", out_err, 0);

    // zero-wait loads and stores
    access("lw",  1'b0, 3'b010, 32'h8000_0004, 32'h0, 32'hDEAD_BEEF, 0, 0, 0,
           32'h8000_0004, 32'h0, 4'h0, 32'hDEAD_BEEF);
    access("lb",  1'b0, 3'b000, 32'h8000_0003, 32'h0, 32'h80FF_0000, 0, 0, 0,
           32'h8000_0000, 32'h0, 4'h0, 32'hFFFF_FF80);
    access("lbu", 1'b0, 3'b100, 32'h8000_0003, 32'h0, 32'h80FF_0000, 0, 0, 0,
           32'h8000_0000, 32'h0, 4'h0, 32'h0000_0080);
    access("lhu", 1'b0, 3'b101, 32'h8000_0002, 32'h0, 32'h80FF_0000, 0, 0, 0,
           32'h8000_0000, 32'h0, 4'h0, 32'h0000_80FF);
    access("sb",  1'b1, 3'b000, 32'h8000_0001, 32'h1234_5678, 32'hCAFE_F00D, 0, 0, 0,
           32'h8000_0000, 32'h7878_7878, 4'b0010, 32'h0);
    access("sh",  1'b1, 3'b001, 32'h8000_0002, 32'h1234_5678, 32'hCAFE_F00D, 0, 0, 0,
           32'h8000_0000, 32'h5678_5678, 4'b1100, 32'h0);
    access("ld011", 1'b0, 3'b011, 32'h8000_000C, 32'h0, 32'h8765_4321, 0, 0, 0,
           32'h8000_000C, 32'h0, 4'h0, 32'h8765_4321);

    // stalls on every handshake
    access("lh_stall", 1'b0, 3'b001, 32'h8000_0006, 32'h0, 32'h9ABC_1234, 3, 2, 2,
           32'h8000_0004, 32'h0, 4'h0, 32'hFFFF_9ABC);
    access("sw_stall", 1'b1, 3'b010, 32'h8000_0008, 32'hA5A5_5A5A, 32'h0, 3, 2, 2,
           32'h8000_0008, 32'hA5A5_5A5A, 4'b1111, 32'h0);

    // reset while a response is pending
    @(negedge clk);
    in_valid = 1'b1; in_wen = 1'b0; in_funct3 = 3'b010; in_addr = 32'h8000_0010;
    mem_req_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0; mem_req_ready = 1'b1;
    @(negedge clk);
    check("rstmid.in_resp", mem_resp_ready, 1);
    rst_n = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 32'h55AA_55AA; mem_req_ready = 1'b0;
    @(negedge clk);
    check("rstmid.in_ready", in_ready, 0);
    check("rstmid.resp_ready", mem_resp_ready, 0);
    check("rstmid.out_valid", out_valid, 0);
    check("rstmid.out_rdata", out_rdata, 0);
    check("rstmid.req_valid", mem_req_valid, 0);
    check("rstmid.state", dbg_state, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rstmid.idle_ready", in_ready, 1);
    check("rstmid.resp_ignored", mem_resp_ready, 0);
    check("rstmid.no_out", out_valid, 0);
    @(negedge clk);
    check("rstmid.still_no_out", out_valid, 0);
    mem_resp_valid = 1'b0;
    access("lw_after_rst", 1'b0, 3'b010, 32'h8000_0020, 32'h0, 32'h0123_4567, 0, 0, 0,
           32'h8000_0020, 32'h0, 4'h0, 32'h0123_4567);

    // misaligned accesses
`ifdef LSU_MISALIGN_CHECK_EN
    misaligned("lw_mis", 1'b0, 3'b010, 32'h8000_0002);
    misaligned("sh_mis", 1'b1, 3'b001, 32'h8000_0001);
`else
    access("lw_mis", 1'b0, 3'b010, 32'h8000_0002, 32'h0, 32'h1122_3344, 0, 0, 0,
           32'h8000_0000, 32'h0, 4'h0, 32'h1122_3344);
    access("sh_mis", 1'b1, 3'b001, 32'h8000_0001, 32'h0000_BEEF, 32'h0, 0, 0, 0,
           32'h8000_0000, 32'hBEEF_BEEF, 4'b0011, 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
